// File: rtl/hdmi_counter_overlay_if.sv
// Pixel-side bundle between the HDMI output stage (master) and the counter overlay source (slave).
interface hdmi_counter_overlay_if #(
    parameter int NUM_DIGITS = 4
);
    logic [9:0]              cx;
    logic [9:0]              cy;
    logic                    pause;
    logic                    clear;
    logic [23:0]             rgb;
    logic [4*NUM_DIGITS-1:0] count_bcd;

    modport master (output cx, cy, pause, clear, input rgb, count_bcd);
    modport slave  (input cx, cy, pause, clear, output rgb, count_bcd);
endinterface

// File: rtl/hdmi_counter_overlay.sv
// Frame-driven BCD counter rendered as scaled 8x8 glyphs; rgb is aligned to the cx/cy of the same cycle.
// Optional leading-zero blanking is enabled by defining HDMI_OVERLAY_ZERO_BLANK_EN.
module hdmi_counter_overlay #(
    parameter int          FRAME_WIDTH      = 800,
    parameter int          SCREEN_WIDTH     = 640,
    parameter int          SCREEN_HEIGHT    = 480,
    parameter int          NUM_DIGITS       = 4,
    parameter int          FRAMES_PER_COUNT = 60,
    parameter int          ORIGIN_X         = 64,
    parameter int          ORIGIN_Y         = 32,
    parameter int          SCALE_LOG2       = 2,
    parameter logic [23:0] FG_COLOR         = 24'hFFFFFF,
    parameter logic [23:0] BG_COLOR         = 24'h000080
) (
    input  logic                   CLK_PIXEL,
    input  logic                   RESET,
    hdmi_counter_overlay_if.slave  bus
);
    localparam int            CW         = 4 * NUM_DIGITS;
    localparam int            GLYPH_PX   = 8 << SCALE_LOG2;
    localparam int            PW         = (FRAMES_PER_COUNT > 1) ? $clog2(FRAMES_PER_COUNT) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(FRAMES_PER_COUNT - 1);
    localparam logic [10:0]   X_LO       = 11'(ORIGIN_X);
    localparam logic [10:0]   X_HI       = 11'(ORIGIN_X + NUM_DIGITS * GLYPH_PX);
    localparam logic [9:0]    Y_LO       = 10'(ORIGIN_Y);
    localparam logic [9:0]    Y_HI       = 10'(ORIGIN_Y + GLYPH_PX);

    function automatic logic [7:0] font_row(input logic [3:0] digit, input logic [2:0] row);
        logic [63:0] glyph;
        case (digit)
            4'd0:    glyph = 64'h3C66_6E76_6666_3C00;
            4'd1:    glyph = 64'h1838_1818_1818_7E00;
            4'd2:    glyph = 64'h3C66_060C_3060_7E00;
            4'd3:    glyph = 64'h3C66_061C_0666_3C00;
            4'd4:    glyph = 64'h0C1C_3C6C_7E0C_0C00;
            4'd5:    glyph = 64'h7E60_7C06_0666_3C00;
            4'd6:    glyph = 64'h3C66_607C_6666_3C00;
            4'd7:    glyph = 64'h7E66_0C18_1818_1800;
            4'd8:    glyph = 64'h3C66_663C_6666_3C00;
            4'd9:    glyph = 64'h3C66_663E_0666_3C00;
            default: glyph = 64'h0;
        endcase
        return glyph[{~row, 3'b000} +: 8];
    endfunction

    function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        logic          carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    logic [PW-1:0]  presc_q, presc_d;
    logic [CW-1:0]  count_q, count_d;
    logic [10:0]    s1_x_q, s1_x_d;
    logic [9:0]     s1_y_q, s1_y_d;
    logic           s1_act_q, s1_act_d;
    logic [23:0]    rgb_q, rgb_d;

    logic           frame_evt;
    logic [10:0]    xa;
    logic [10:0]    dx;
    logic [9:0]     dy;
    logic           in_region;
    logic [2:0]     digit_sel;
    logic [3:0]     nib;
    logic           suppress;
    logic [7:0]     glyph_byte;
    logic           pix_on;
    logic [NUM_DIGITS-1:0] lead_blank;

    assign frame_evt = (bus.cx == 10'd0) && (bus.cy == 10'(SCREEN_HEIGHT));

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        presc_d = presc_q;
        count_d = count_q;
        if (bus.clear) begin
            presc_d = '0;
            count_d = '0;
        end else if (!bus.pause && frame_evt) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                count_d = bcd_inc(count_q);
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    // Look two pixels ahead so the two register stages land on the current cx.
    always_comb begin
        xa       = {1'b0, bus.cx} + 11'd2;
        s1_x_d   = xa;
        s1_y_d   = bus.cy;
        s1_act_d = (xa < 11'(FRAME_WIDTH)) && (xa < 11'(SCREEN_WIDTH))
                   && (bus.cy < 10'(SCREEN_HEIGHT));
    end

`ifdef HDMI_OVERLAY_ZERO_BLANK_EN
    logic zero_run;
    always_comb begin
        lead_blank = '0;
        zero_run   = 1'b1;
        for (int i = 0; i < NUM_DIGITS - 1; i++) begin
            zero_run      = zero_run && (count_q[4*(NUM_DIGITS-1-i) +: 4] == 4'd0);
            lead_blank[i] = zero_run;
        end
    end
`else
    assign lead_blank = '0;
`endif

    // Second stage folds digit select, font fetch and colour choice into the output register.
    always_comb begin
        dx         = s1_x_q - X_LO;
        dy         = s1_y_q - Y_LO;
        in_region  = (s1_x_q >= X_LO) && (s1_x_q < X_HI) && (s1_y_q >= Y_LO) && (s1_y_q < Y_HI);
        digit_sel  = 3'(dx >> (SCALE_LOG2 + 3));
        nib        = 4'd0;
        suppress   = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_sel == 3'(i)) begin
                nib      = count_q[4*(NUM_DIGITS-1-i) +: 4];
                suppress = lead_blank[i];
            end
        end
        glyph_byte = font_row(nib, 3'(dy >> SCALE_LOG2));
        pix_on     = glyph_byte[~(3'(dx >> SCALE_LOG2))];
        if (!s1_act_q) begin
            rgb_d = 24'h000000;
        end else if (in_region && pix_on && !suppress) begin
            rgb_d = FG_COLOR;
        end else begin
            rgb_d = BG_COLOR;
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK_PIXEL) begin
        if (RESET) begin
            presc_q  <= '0;
            count_q  <= '0;
            s1_x_q   <= '0;
            s1_y_q   <= '0;
            s1_act_q <= 1'b0;
            rgb_q    <= '0;
        end else begin
            presc_q  <= presc_d;
            count_q  <= count_d;
            s1_x_q   <= s1_x_d;
            s1_y_q   <= s1_y_d;
            s1_act_q <= s1_act_d;
            rgb_q    <= rgb_d;
        end
    end

    assign bus.rgb       = rgb_q;
    assign bus.count_bcd = count_q;
endmodule
